vga_sync_ctrl: RTL and testbench
================================

Name: vga_sync_ctrl

Overview:
- VGA timing sequencer for the 640x480 display path.
- Consumes the 25 MHz pixel-enable pulse from the clock-divider ticker (one clk-wide pulse every 4 clk cycles at 100 MHz).
- Sequences horizontal and vertical timing phases and produces pixel coordinates, sync strobes, a blanking flag and frame/line markers.
- Downstream pixel generators use these outputs.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- Constraints: each sum (H_* and V_*) is ≤ 1024; every parameter is ≥ 1.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-low reset; 0 resets the block
- tick  input  1  pixel enable, one clk wide; all state advances only when tick=1
- h_count  output  10  current pixel column, 0..H_TOTAL-1
- v_count  output  10  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- video_on  output  1  1 while h_count<H_DISPLAY and v_count<V_DISPLAY
- line_end  output  1  one-clk pulse on the tick where h_count==H_TOTAL-1
- frame_start  output  1  one-clk pulse on the clk following the wrap to (0,0)

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters (default 800); V_TOTAL = sum of the V_* parameters (default 525).
- Reset (reset=0, asynchronous):
  - h_count=0, v_count=0
  - h_state=H_DISP, v_state=V_DISP
  - hsync=1, vsync=1, video_on=1, line_end=0, frame_start=0
- Holding: when tick=0, every register holds; line_end and frame_start are 0.
- Horizontal FSM (advances on tick=1 only): H_DISP -> H_FP -> H_SYNC -> H_BP -> H_DISP.
  - H_DISP -> H_FP when h_count reaches H_DISPLAY.
  - H_FP -> H_SYNC when h_count reaches H_DISPLAY+H_FRONT.
  - H_SYNC -> H_BP when h_count reaches H_DISPLAY+H_FRONT+H_SYNC.
  - H_BP -> H_DISP when h_count wraps to 0.
- h_count update on tick=1: next value is 0 if h_count==H_TOTAL-1, else h_count+1.
- Vertical FSM: same structure (V_DISP, V_FP, V_SYNC, V_BP), advanced only on a tick where h_count wraps.
  - v_count increments on that tick.
  - v_count goes to 0 when v_count==V_TOTAL-1 at the same wrap.
- Output timing:
  - hsync, vsync and video_on are registered and updated on the same edge as the counters, so they always decode the displayed h_count/v_count. No extra latency.
  - hsync=0 exactly when h_state==H_SYNC.
  - vsync=0 exactly when v_state==V_SYNC.
  - video_on = (h_state==H_DISP) && (v_state==V_DISP).
- Markers:
  - line_end=1 for the single clk in which tick=1 and h_count==H_TOTAL-1.
  - frame_start=1 for one clk, registered on the edge where (h_count,v_count) transitions from (H_TOTAL-1,V_TOTAL-1) to (0,0).
- Consecutive ticks (tick held high every clk) are legal; the block then advances one pixel per clk.
- Reset asserted mid-frame: state returns to reset values immediately. Counting resumes at (0,0) on the first tick after reset deasserts. No frame_start pulse is generated by reset.
- Counter arithmetic is 10-bit unsigned; counters never exceed H_TOTAL-1 / V_TOTAL-1.

Test Plan:
1. Reset, then tick every 4th clk for 800 ticks -> h_count runs 0..799 then 0; v_count=1 after the wrap; line_end pulses once on the tick at h_count=799.
2. Default params, one line of ticks -> hsync=0 for exactly 96 ticks, h_count 656..751; video_on=1 for h_count 0..639 and 0 for 640..799.
3. Full frame (420000 ticks) -> vsync=0 only on lines 490..491 (1600 ticks); video_on=0 for all of lines 480..524; exactly one frame_start, after (799,524)->(0,0).
4. Irregular tick gaps (0..7 clk idle between ticks) -> counts, syncs and video_on identical per tick to scenario 1; all outputs stable while tick=0.
5. Reset pulsed low at (h=300,v=200) -> outputs immediately h=0, v=0, hsync=1, vsync=1, video_on=1; no frame_start; next tick gives h=1.
6. Small params (H=4/1/2/1, V=3/1/1/1), tick every clk -> h period 8, v period 6; hsync low at h=5,6; vsync low at v=4; frame_start every 48 clks.

Source files
------------

// File: rtl/vga_sync_ctrl.sv
// VGA timing sequencer: horizontal/vertical phase FSMs driven by a pixel-enable tick,
// producing pixel coordinates, active-low syncs, blanking flag and line/frame markers.
//
// state  | meaning
// -------+------------------------------------------
// S_DISP | visible region (pixels / lines shown)
// S_FP   | front porch
// S_SYNC | sync pulse (hsync / vsync driven low)
// S_BP   | back porch, ends when the counter wraps
module vga_sync_ctrl #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_end,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START = 10'(H_DISPLAY);
    localparam logic [9:0] H_SY_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_BP_START = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START = 10'(V_DISPLAY);
    localparam logic [9:0] V_SY_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_BP_START = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {S_DISP, S_FP, S_SYNC, S_BP} phase_e;

    phase_e     h_state_q, h_state_d;
    phase_e     v_state_q, v_state_d;
    logic [9:0] h_count_q, h_count_d;
    logic [9:0] v_count_q, v_count_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic       frame_start_q, frame_start_d;
    logic       h_wrap;

    assign h_wrap = tick && (h_count_q == H_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_state_q     <= S_DISP;
            v_state_q     <= S_DISP;
            h_count_q     <= '0;
            v_count_q     <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        if (tick) begin
            h_count_d = (h_count_q == H_LAST) ? 10'd0 : h_count_q + 10'd1;
        end
        if (h_wrap) begin
            v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
        end
    end

    // Phase transitions key off the next count so state and count land on the same edge.
    always_comb begin
        h_state_d = h_state_q;
        if (tick) begin
            case (h_state_q)
                S_DISP:  if (h_count_d == H_FP_START) h_state_d = S_FP;
                S_FP:    if (h_count_d == H_SY_START) h_state_d = S_SYNC;
                S_SYNC:  if (h_count_d == H_BP_START) h_state_d = S_BP;
                S_BP:    if (h_count_d == 10'd0)      h_state_d = S_DISP;
                default: h_state_d = S_DISP;
            endcase
        end
    end

    always_comb begin
        v_state_d = v_state_q;
        if (h_wrap) begin
            case (v_state_q)
                S_DISP:  if (v_count_d == V_FP_START) v_state_d = S_FP;
                S_FP:    if (v_count_d == V_SY_START) v_state_d = S_SYNC;
                S_SYNC:  if (v_count_d == V_BP_START) v_state_d = S_BP;
                S_BP:    if (v_count_d == 10'd0)      v_state_d = S_DISP;
                default: v_state_d = S_DISP;
            endcase
        end
    end

    always_comb begin
        hsync_d       = (h_state_d != S_SYNC);
        vsync_d       = (v_state_d != S_SYNC);
        video_on_d    = (h_state_d == S_DISP) && (v_state_d == S_DISP);
        frame_start_d = h_wrap && (v_count_q == V_LAST);
    end

    assign h_count     = h_count_q;
    assign v_count     = v_count_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_end    = h_wrap;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl: three parameterisations share clk/reset/tick and are checked
// every cycle against a linear pixel-index model, plus literal spot checks.
module tb_vga_sync_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;

    logic [9:0] h_o [3];
    logic [9:0] v_o [3];
    logic       hs_o [3];
    logic       vs_o [3];
    logic       vo_o [3];
    logic       le_o [3];
    logic       fs_o [3];

    // 0: default timing, 1: default horizontal / short frame, 2: tiny timing
    int hd [3] = '{640, 640, 4};
    int hf [3] = '{16, 16, 1};
    int hsw[3] = '{96, 96, 2};
    int hb [3] = '{48, 48, 1};
    int vd [3] = '{480, 4, 3};
    int vf [3] = '{10, 2, 1};
    int vsw[3] = '{2, 2, 1};
    int vb [3] = '{33, 2, 1};

    int idx [3];
    int fs_exp [3];
    int fs_cnt [3];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vga_sync_ctrl u_def (
        .clk(clk), .reset(reset), .tick(tick),
        .h_count(h_o[0]), .v_count(v_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]),
        .video_on(vo_o[0]), .line_end(le_o[0]), .frame_start(fs_o[0])
    );

    vga_sync_ctrl #(
        .V_DISPLAY(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u_mid (
        .clk(clk), .reset(reset), .tick(tick),
        .h_count(h_o[1]), .v_count(v_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]),
        .video_on(vo_o[1]), .line_end(le_o[1]), .frame_start(fs_o[1])
    );

    vga_sync_ctrl #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_small (
        .clk(clk), .reset(reset), .tick(tick),
        .h_count(h_o[2]), .v_count(v_o[2]), .hsync(hs_o[2]), .vsync(vs_o[2]),
        .video_on(vo_o[2]), .line_end(le_o[2]), .frame_start(fs_o[2])
    );

    function automatic int h_tot(input int i);
        return hd[i] + hf[i] + hsw[i] + hb[i];
    endfunction

    function automatic int v_tot(input int i);
        return vd[i] + vf[i] + vsw[i] + vb[i];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Position is a single pixel index into the frame; everything else is derived from it.
    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                idx[i]    = 0;
                fs_exp[i] = 0;
            end else begin
                fs_exp[i] = (tick && idx[i] == h_tot(i) * v_tot(i) - 1) ? 1 : 0;
                if (tick) idx[i] = (idx[i] + 1) % (h_tot(i) * v_tot(i));
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int h, v, hs_e, vs_e, vo_e, le_e;
            h    = idx[i] % h_tot(i);
            v    = idx[i] / h_tot(i);
            hs_e = (h >= hd[i] + hf[i] && h < hd[i] + hf[i] + hsw[i]) ? 0 : 1;
            vs_e = (v >= vd[i] + vf[i] && v < vd[i] + vf[i] + vsw[i]) ? 0 : 1;
            vo_e = (h < hd[i] && v < vd[i]) ? 1 : 0;
            le_e = (tick && h == h_tot(i) - 1) ? 1 : 0;
            check($sformatf("dut%0d h_count", i), int'(h_o[i]), h);
            check($sformatf("dut%0d v_count", i), int'(v_o[i]), v);
            check($sformatf("dut%0d hsync", i), int'(hs_o[i]), hs_e);
            check($sformatf("dut%0d vsync", i), int'(vs_o[i]), vs_e);
            check($sformatf("dut%0d video_on", i), int'(vo_o[i]), vo_e);
            check($sformatf("dut%0d line_end", i), int'(le_o[i]), le_e);
            check($sformatf("dut%0d frame_start", i), int'(fs_o[i]), fs_exp[i]);
            if (fs_o[i]) fs_cnt[i]++;
        end
    end

    initial begin
        int hs_low, h_min, h_max, von, le_cnt;
        for (int i = 0; i < 3; i++) fs_cnt[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset h_count", int'(h_o[0]), 0);
        check("reset v_count", int'(v_o[0]), 0);
        check("reset hsync", int'(hs_o[0]), 1);
        check("reset vsync", int'(vs_o[0]), 1);
        check("reset video_on", int'(vo_o[0]), 1);
        check("reset frame_start", int'(fs_o[0]), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // one line at one tick per 4 clk
        hs_low = 0; h_min = 1023; h_max = -1; von = 0; le_cnt = 0;
        for (int k = 0; k < 800; k++) begin
            tick = 1'b1;
            #1;
            if (le_o[0]) le_cnt++;
            @(posedge clk);
            #1;
            tick = 1'b0;
            if (!hs_o[0]) begin
                hs_low++;
                if (int'(h_o[0]) < h_min) h_min = int'(h_o[0]);
                if (int'(h_o[0]) > h_max) h_max = int'(h_o[0]);
            end
            if (vo_o[0]) von++;
            repeat (3) begin @(posedge clk); #1; end
        end
        check("line h_count wrap", int'(h_o[0]), 0);
        check("line v_count after wrap", int'(v_o[0]), 1);
        check("line line_end pulses", le_cnt, 1);
        check("line hsync low ticks", hs_low, 96);
        check("line hsync first h", h_min, 656);
        check("line hsync last h", h_max, 751);
        check("line video_on ticks", von, 640);
        check("mid v_count after line", int'(v_o[1]), 1);
        check("small h_count at 800", int'(h_o[2]), 0);
        check("small v_count at 800", int'(v_o[2]), 4);
        check("small vsync at v=4", int'(vs_o[2]), 0);

        // irregular gaps between ticks
        for (int k = 0; k < 1000; k++) begin
            int gap;
            gap = $urandom_range(0, 7);
            tick = 1'b1;
            @(posedge clk);
            #1;
            tick = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end

        // back-to-back ticks across two short frames
        tick = 1'b1;
        repeat (17000) @(posedge clk);
        #1;
        tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("def frame_start count", fs_cnt[0], 0);
        check("mid frame_start count", fs_cnt[1], 2);
        check("small frame_start count", fs_cnt[2], 391);

        // asynchronous reset mid-frame
        reset = 1'b0;
        #1;
        check("midreset h_count", int'(h_o[0]), 0);
        check("midreset v_count", int'(v_o[0]), 0);
        check("midreset hsync", int'(hs_o[0]), 1);
        check("midreset vsync", int'(vs_o[0]), 1);
        check("midreset video_on", int'(vo_o[0]), 1);
        check("midreset frame_start", int'(fs_o[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        check("post-reset h_count", int'(h_o[0]), 1);
        check("post-reset frame_start", int'(fs_o[0]), 0);
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
